// File: rtl/req_enc_pkg.sv
// rtl/req_enc_pkg.sv - shared constants and helpers for the request encoder
// Purpose: line count, code width, the "no line" code, the request mask and
//          the code-to-one-hot mapping shared with the 3-to-8 decoder.
// Ports:   none (package).
package req_enc_pkg;

   localparam int          N_REQ     = 8;
   localparam int          CODE_W    = 3;
   localparam logic [2:0]  CODE_NONE = 3'd0;
   // Bit 0 is not a line: code 0 is reserved for "no line".
   localparam logic [7:0]  REQ_MASK  = 8'hFE;

   // Same mapping as the decoder, so an emitted code reproduces its line.
   function automatic logic [N_REQ-1:0] code_to_onehot(input logic [CODE_W-1:0] c);
      logic [N_REQ-1:0] v;
      v = '0;
      if (c != CODE_NONE) begin
         v = N_REQ'(1) << c;
      end
      return v;
   endfunction

endpackage

// File: rtl/req_encoder_prio_pick.sv
// rtl/req_encoder_prio_pick.sv - combinational priority pick over pending lines
// Purpose: select one pending line (highest or lowest index) among lines 1..7.
// Ports:   pending  in  8  pending lines (bit 0 ignored)
//          any      out 1  at least one of lines 1..7 pending
//          idx      out 3  selected line index, 0 when none
//          grant_oh out 8  one-hot of the selected line, 0 when none
module prio_pick
   import req_enc_pkg::*;
#(
   parameter bit PRIO_HIGH = 1'b1
) (
   input  logic [N_REQ-1:0]  pending,
   output logic              any,
   output logic [CODE_W-1:0] idx,
   output logic [N_REQ-1:0]  grant_oh
);

   logic [N_REQ-1:0] w_lines;

   assign w_lines = pending & REQ_MASK;
   assign any     = |w_lines;

   // Scan so that the winning line is the last one written.
   always_comb begin
      idx = CODE_NONE;
      if (PRIO_HIGH) begin
         for (int i = 1; i < N_REQ; i++) begin
            if (w_lines[i]) idx = CODE_W'(i);
         end
      end else begin
         for (int i = N_REQ - 1; i >= 1; i--) begin
            if (w_lines[i]) idx = CODE_W'(i);
         end
      end
   end

   assign grant_oh = code_to_onehot(idx);

endmodule

// File: rtl/req_encoder.sv
// rtl/req_encoder.sv - sequential 8-to-3 priority encoder with valid/ready output
// Purpose: capture request lines 1..7 into a sticky pending register and emit
//          the highest-priority pending line as a code, one per handshake.
// Ports:   clk     in  1  clock, rising edge
//          rst     in  1  asynchronous active-low reset
//          req     in  8  request lines (bit 0 ignored)
//          code    out 3  granted line index, 0 when valid=0
//          valid   out 1  code holds a granted request
//          ready   in  1  consumer accepts code when valid=1
//          pending out 8  sticky pending register, bit 0 always 0
module req_encoder
   import req_enc_pkg::*;
#(
   parameter bit PRIO_HIGH = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_REQ-1:0]  req,
   output logic [CODE_W-1:0] code,
   output logic              valid,
   input  logic              ready,
   output logic [N_REQ-1:0]  pending
);

   logic [N_REQ-1:0]  r_pending;
   logic [CODE_W-1:0] r_code;
   logic              r_valid;

   logic              w_free;
   logic              w_any;
   logic [CODE_W-1:0] w_idx;
   logic [N_REQ-1:0]  w_grant_oh;
   logic              w_grant;
   logic [N_REQ-1:0]  w_clr;

   // Selection looks only at the registered pending state, never at req.
   prio_pick #(.PRIO_HIGH(PRIO_HIGH)) u_pick (
      .pending  (r_pending),
      .any      (w_any),
      .idx      (w_idx),
      .grant_oh (w_grant_oh)
   );

   assign w_free  = !r_valid || ready;
   assign w_grant = w_free && w_any;
   assign w_clr   = w_grant ? w_grant_oh : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pending <= '0;
         r_code    <= CODE_NONE;
         r_valid   <= 1'b0;
      end else begin
         // Set is applied after clear so a re-asserted line stays pending.
         r_pending <= (r_pending & ~w_clr) | (req & REQ_MASK);
         if (w_free) begin
            r_valid <= w_any;
            r_code  <= w_any ? w_idx : CODE_NONE;
         end
      end
   end

   assign code    = r_code;
   assign valid   = r_valid;
   assign pending = r_pending;

endmodule

// File: tb/tb_req_encoder.sv
// tb/tb_req_encoder.sv - scoreboard bench for req_encoder in both priority directions
module tb_req_encoder;
   import req_enc_pkg::*;

   logic       clk;
   logic       rst;
   logic [7:0] req;
   logic       ready;
   logic [2:0] code_hi, code_lo;
   logic       valid_hi, valid_lo;
   logic [7:0] pend_hi, pend_lo;

   int n_tests = 0;
   int n_fail  = 0;

   logic [2:0] q_hi[$];
   logic [2:0] q_lo[$];

   req_encoder #(.PRIO_HIGH(1'b1)) dut_hi (
      .clk(clk), .rst(rst), .req(req), .code(code_hi),
      .valid(valid_hi), .ready(ready), .pending(pend_hi)
   );

   req_encoder #(.PRIO_HIGH(1'b0)) dut_lo (
      .clk(clk), .rst(rst), .req(req), .code(code_lo),
      .valid(valid_lo), .ready(ready), .pending(pend_lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Inputs change 1 time unit after the rising edge.
   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push2(input logic [2:0] h, input logic [2:0] l);
      q_hi.push_back(h);
      q_lo.push_back(l);
   endtask

   // Scoreboard: at the falling edge, valid&&ready means the code is taken on the next rising edge.
   always @(negedge clk) begin
      if (rst) begin
         if (valid_hi && ready) begin
            if (q_hi.size() == 0) chk("hi_unexpected_code", {29'd0, code_hi}, 32'hFFFF);
            else chk("hi_code", {29'd0, code_hi}, {29'd0, q_hi.pop_front()});
         end
         if (valid_lo && ready) begin
            if (q_lo.size() == 0) chk("lo_unexpected_code", {29'd0, code_lo}, 32'hFFFF);
            else chk("lo_code", {29'd0, code_lo}, {29'd0, q_lo.pop_front()});
         end
         if (!valid_hi) chk("hi_code_idle", {29'd0, code_hi}, 0);
         if (!valid_lo) chk("lo_code_idle", {29'd0, code_lo}, 0);
      end
   end

   initial begin
      rst   = 1'b0;
      req   = 8'h00;
      ready = 1'b0;
      #3;
      chk("rst_pend_hi", pend_hi, 0);
      chk("rst_valid_hi", valid_hi, 0);
      chk("rst_code_lo", code_lo, 0);
      tick(2);
      rst = 1'b1;

      // Single request
      ready = 1'b1; req = 8'h20; push2(3'd5, 3'd5);
      tick(1); req = 8'h00;
      chk("t1_pend", pend_hi, 8'h20);
      chk("t1_novalid", valid_hi, 0);
      tick(1);
      chk("t1_valid", valid_hi, 1);
      chk("t1_code", code_hi, 5);
      chk("t1_onehot", code_to_onehot(code_hi), 8'h20);
      tick(1);
      chk("t1_valid_off", valid_hi, 0);
      chk("t1_pend_off", pend_hi, 0);

      // Priority order
      req = 8'h8A; push2(3'd7, 3'd1); push2(3'd3, 3'd3); push2(3'd1, 3'd7);
      tick(1); req = 8'h00;
      chk("t2_hi_p0", pend_hi, 8'h8A);
      chk("t2_lo_p0", pend_lo, 8'h8A);
      tick(1);
      chk("t2_hi_p1", pend_hi, 8'h0A);
      chk("t2_lo_p1", pend_lo, 8'h88);
      tick(1);
      chk("t2_hi_p2", pend_hi, 8'h02);
      chk("t2_lo_p2", pend_lo, 8'h80);
      tick(1);
      chk("t2_hi_p3", pend_hi, 8'h00);
      chk("t2_lo_p3", pend_lo, 8'h00);
      chk("t2_lo_last", code_lo, 7);
      tick(1);
      chk("t2_idle", {valid_hi, valid_lo}, 0);

      // Backpressure
      ready = 1'b0; req = 8'h0C; push2(3'd3, 3'd2); push2(3'd2, 3'd3);
      tick(1); req = 8'h00;
      for (int c = 0; c < 5; c++) begin
         tick(1);
         chk("t3_code", code_hi, 3);
         chk("t3_valid", valid_hi, 1);
         chk("t3_pend", pend_hi, 8'h04);
         chk("t3_lo_code", code_lo, 2);
      end
      ready = 1'b1;
      tick(1);
      chk("t3_next", code_hi, 2);
      chk("t3_pend_end", pend_hi, 0);
      tick(1);
      chk("t3_idle", valid_hi, 0);

      // Bit 0 ignored
      req = 8'h01;
      for (int c = 0; c < 4; c++) begin
         tick(1);
         chk("t4_b0_valid", valid_hi | valid_lo, 0);
         chk("t4_b0_pend", pend_hi | pend_lo, 0);
      end
      // Merge: hold the slot with line 1, pulse line 4 twice while pending
      ready = 1'b0; req = 8'h02; push2(3'd1, 3'd1); push2(3'd4, 3'd4);
      tick(1); req = 8'h00;
      tick(1);
      req = 8'h10; tick(1); req = 8'h00; tick(1);
      req = 8'h10; tick(1); req = 8'h00;
      chk("t4_merge_pend", pend_hi, 8'h10);
      chk("t4_merge_code", code_hi, 1);
      ready = 1'b1;
      tick(1);
      chk("t4_merge_pend0", pend_hi, 0);
      tick(1);
      chk("t4_merge_idle", valid_hi | valid_lo, 0);

      // Set/clear collision: req held for 6 edges gives 6 grants
      req = 8'h08;
      for (int c = 0; c < 6; c++) push2(3'd3, 3'd3);
      tick(1);
      for (int c = 0; c < 5; c++) begin
         tick(1);
         chk("t5_valid", valid_hi, 1);
         chk("t5_code", code_hi, 3);
         chk("t5_pend3", pend_hi[3], 1);
      end
      req = 8'h00;
      tick(1);
      chk("t5_pend_clear", pend_hi, 0);
      tick(1);
      chk("t5_idle", valid_hi, 0);

      // Reset mid-operation
      ready = 1'b0; req = 8'hF0;
      tick(2);
      chk("t6_pre_pend", pend_hi, 8'hF0);
      chk("t6_pre_valid", valid_hi, 1);
      chk("t6_pre_lo", code_lo, 4);
      #2; rst = 1'b0; req = 8'h00;
      #1;
      chk("t6_async_valid", {valid_hi, valid_lo}, 0);
      chk("t6_async_code", {code_hi, code_lo}, 0);
      chk("t6_async_pend", {pend_hi, pend_lo}, 0);
      tick(1);
      rst = 1'b1; ready = 1'b1; req = 8'h40; push2(3'd6, 3'd6);
      tick(1); req = 8'h00;
      chk("t6_post_novalid", valid_hi, 0);
      tick(1);
      chk("t6_post_code", code_hi, 6);
      chk("t6_post_valid", valid_lo, 1);
      tick(2);

      chk("q_hi_drained", q_hi.size(), 0);
      chk("q_lo_drained", q_lo.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
